// File: rtl/test_pattern_gen.sv
// Selectable video test-pattern source (EBU bars, grey ramp, checker, scrolling bars, solid colour).
// Latency: fixed 2 core cycles from counter/config state to out_r/g/b/out_valid.
// No backpressure: runs every cycle; newpixel only advances the pixel counter.
module test_pattern_gen #(
    parameter int H_PIXELS    = 256,
    parameter int DEPTH       = 8,
    parameter int CHECK_LOG2  = 4,
    parameter int SCROLL_STEP = 1,
    parameter int LINE_W      = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 newframe,
    input  logic                 newline,
    input  logic                 newpixel,
    input  logic                 visible_window,
    input  logic [2:0]           mode,
    input  logic                 level_100,
    input  logic                 reverse,
    input  logic [3*DEPTH-1:0]   solid_rgb,
    output logic [DEPTH-1:0]     out_r,
    output logic [DEPTH-1:0]     out_g,
    output logic [DEPTH-1:0]     out_b,
    output logic                 out_valid
);

    localparam int HW = $clog2(H_PIXELS);

    localparam logic [HW:0]       PX_MAX = (HW+1)'(H_PIXELS);
    localparam logic [HW:0]       PX_ONE = (HW+1)'(1);
    localparam logic [LINE_W-1:0] LY_ONE = LINE_W'(1);
    localparam logic [HW-1:0]     STEP   = HW'(SCROLL_STEP);
    localparam logic [DEPTH-1:0]  FULL   = {DEPTH{1'b1}};
    localparam logic [DEPTH-1:0]  L75    = DEPTH'(((2**DEPTH - 1) * 3) >> 2);

    localparam logic [2:0] MODE_BARS   = 3'd0;
    localparam logic [2:0] MODE_RAMP   = 3'd1;
    localparam logic [2:0] MODE_CHECK  = 3'd2;
    localparam logic [2:0] MODE_SCROLL = 3'd3;
    localparam logic [2:0] MODE_SOLID  = 3'd4;

    // Counters and line-shadowed configuration
    logic [HW:0]          pixel_x_q,  pixel_x_d;
    logic [LINE_W-1:0]    line_y_q,   line_y_d;
    logic [HW-1:0]        scroll_q,   scroll_d;
    logic [2:0]           sh_mode_q,  sh_mode_d;
    logic                 sh_lvl_q,   sh_lvl_d;
    logic                 sh_rev_q,   sh_rev_d;

    // Stage 1: pattern primitives
    logic                 s1_vld_q,   s1_vld_d;
    logic [2:0]           s1_mode_q,  s1_mode_d;
    logic [DEPTH-1:0]     s1_lvl_q,   s1_lvl_d;
    logic [2:0]           s1_idx_q,   s1_idx_d;
    logic                 s1_cell_q,  s1_cell_d;
    logic [DEPTH-1:0]     s1_grey_q,  s1_grey_d;
    logic [3*DEPTH-1:0]   s1_solid_q, s1_solid_d;

    // Stage 2: final colour
    logic [DEPTH-1:0]     out_r_q, out_r_d;
    logic [DEPTH-1:0]     out_g_q, out_g_d;
    logic [DEPTH-1:0]     out_b_q, out_b_d;
    logic                 out_valid_q, out_valid_d;

    // Position counters, scroll offset and config shadow; config only moves on newline
    always_comb begin
        pixel_x_d = pixel_x_q;
        if (newline)
            pixel_x_d = '0;
        else if (visible_window && newpixel && (pixel_x_q != PX_MAX))
            pixel_x_d = pixel_x_q + PX_ONE;

        line_y_d = line_y_q;
        if (newframe)
            line_y_d = '0;
        else if (newline)
            line_y_d = line_y_q + LY_ONE;

        // H_PIXELS is a power of two, so the natural wrap of HW bits is the modulo
        scroll_d = scroll_q;
        if (newframe && (sh_mode_q == MODE_SCROLL))
            scroll_d = scroll_q + STEP;

        sh_mode_d = sh_mode_q;
        sh_lvl_d  = sh_lvl_q;
        sh_rev_d  = sh_rev_q;
        if (newline) begin
            sh_mode_d = mode;
            sh_lvl_d  = level_100;
            sh_rev_d  = reverse;
        end
    end

    // Stage 1: bar index, checker cell and ramp grey from the current counters
    always_comb begin
        s1_vld_d   = visible_window && !pixel_x_q[HW];
        s1_mode_d  = sh_mode_q;
        s1_lvl_d   = sh_lvl_q ? FULL : L75;
        s1_solid_d = solid_rgb;

        if (sh_mode_q == MODE_SCROLL)
            s1_idx_d = 3'((pixel_x_q[HW-1:0] + scroll_q) >> (HW-3));
        else
            s1_idx_d = 3'(pixel_x_q[HW-1:0] >> (HW-3));
        // reverse mirrors the bar order: 7-idx is the bitwise complement
        s1_idx_d = s1_idx_d ^ {3{sh_rev_q}};

        s1_cell_d = pixel_x_q[CHECK_LOG2] ^ line_y_q[CHECK_LOG2] ^ sh_rev_q;

        // Rescale pixel position to the full DEPTH range; FULL-g is the complement
        s1_grey_d = DEPTH'({pixel_x_q[HW-1:0], {DEPTH{1'b0}}} >> HW);
        s1_grey_d = s1_grey_d ^ {DEPTH{sh_rev_q}};
    end

    // Stage 2: map primitives to RGB, blanking outside the active region
    always_comb begin
        out_r_d     = '0;
        out_g_d     = '0;
        out_b_d     = '0;
        out_valid_d = s1_vld_q;
        if (s1_vld_q) begin
            case (s1_mode_q)
                MODE_BARS, MODE_SCROLL: begin
                    // white,yellow,cyan,green,magenta,red,blue,black
                    out_r_d = s1_idx_q[1] ? '0 : s1_lvl_q;
                    out_g_d = s1_idx_q[2] ? '0 : s1_lvl_q;
                    out_b_d = s1_idx_q[0] ? '0 : s1_lvl_q;
                end
                MODE_RAMP: begin
                    out_r_d = s1_grey_q;
                    out_g_d = s1_grey_q;
                    out_b_d = s1_grey_q;
                end
                MODE_CHECK: begin
                    out_r_d = s1_cell_q ? s1_lvl_q : '0;
                    out_g_d = s1_cell_q ? s1_lvl_q : '0;
                    out_b_d = s1_cell_q ? s1_lvl_q : '0;
                end
                MODE_SOLID: begin
                    out_r_d = s1_solid_q[3*DEPTH-1:2*DEPTH];
                    out_g_d = s1_solid_q[2*DEPTH-1:DEPTH];
                    out_b_d = s1_solid_q[DEPTH-1:0];
                end
                default: ;
            endcase
        end
    end

    // State register for counters, shadow config and both pipeline stages
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x_q   <= '0;
            line_y_q    <= '0;
            scroll_q    <= '0;
            sh_mode_q   <= MODE_BARS;
            sh_lvl_q    <= 1'b1;
            sh_rev_q    <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_mode_q   <= '0;
            s1_lvl_q    <= '0;
            s1_idx_q    <= '0;
            s1_cell_q   <= 1'b0;
            s1_grey_q   <= '0;
            s1_solid_q  <= '0;
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pixel_x_q   <= pixel_x_d;
            line_y_q    <= line_y_d;
            scroll_q    <= scroll_d;
            sh_mode_q   <= sh_mode_d;
            sh_lvl_q    <= sh_lvl_d;
            sh_rev_q    <= sh_rev_d;
            s1_vld_q    <= s1_vld_d;
            s1_mode_q   <= s1_mode_d;
            s1_lvl_q    <= s1_lvl_d;
            s1_idx_q    <= s1_idx_d;
            s1_cell_q   <= s1_cell_d;
            s1_grey_q   <= s1_grey_d;
            s1_solid_q  <= s1_solid_d;
            out_r_q     <= out_r_d;
            out_g_q     <= out_g_d;
            out_b_q     <= out_b_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_r     = out_r_q;
    assign out_g     = out_g_q;
    assign out_b     = out_b_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Randomised bench for test_pattern_gen with a scoreboard queue and arithmetic reference model.
// Expected pixel per cycle is pushed by the driver and popped two cycles later by the monitor.
// The DUT has no backpressure; every cycle yields one checked output.
module tb_test_pattern_gen;

    localparam int H     = 256;
    localparam int DEPTH = 8;
    localparam int CL2   = 4;
    localparam int STEP  = 1;
    localparam int LW    = 10;
    localparam int FULL  = 255;
    localparam int L75   = 191;

    typedef struct {
        int         cyc;
        logic       vld;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        newframe = 1'b0;
    logic        newline = 1'b0;
    logic        newpixel = 1'b0;
    logic        visible_window = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        level_100 = 1'b1;
    logic        reverse = 1'b0;
    logic [23:0] solid_rgb = 24'd0;
    logic [7:0]  out_r, out_g, out_b;
    logic        out_valid;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];

    // Reference model state
    int m_px = 0, m_ly = 0, m_sc = 0, m_mode = 0;
    bit m_l100 = 1'b1, m_rev = 1'b0;

    test_pattern_gen #(
        .H_PIXELS(H), .DEPTH(DEPTH), .CHECK_LOG2(CL2), .SCROLL_STEP(STEP), .LINE_W(LW)
    ) dut (
        .clk(clk), .reset(reset), .newframe(newframe), .newline(newline),
        .newpixel(newpixel), .visible_window(visible_window), .mode(mode),
        .level_100(level_100), .reverse(reverse), .solid_rgb(solid_rgb),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_valid(out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model_out(int px, int ly, int sc, int md, bit l100, bit rv,
                                       bit vis, logic [23:0] sol);
        exp_t       e;
        logic [2:0] tbl [0:7];
        logic [2:0] msk;
        int         lvl, x, idx, gr, c;
        tbl = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        e.cyc = 0; e.vld = 1'b0; e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
        if (!vis || px >= H) return e;
        e.vld = 1'b1;
        lvl = l100 ? FULL : L75;
        case (md)
            0, 3: begin
                x   = (md == 3) ? (px + sc) % H : px;
                idx = x * 8 / H;
                if (rv) idx = 7 - idx;
                msk = tbl[idx];
                e.r = msk[2] ? 8'(lvl) : 8'd0;
                e.g = msk[1] ? 8'(lvl) : 8'd0;
                e.b = msk[0] ? 8'(lvl) : 8'd0;
            end
            1: begin
                gr = px * (FULL + 1) / H;
                if (rv) gr = FULL - gr;
                e.r = 8'(gr); e.g = 8'(gr); e.b = 8'(gr);
            end
            2: begin
                c = ((px >> CL2) & 1) ^ ((ly >> CL2) & 1) ^ int'(rv);
                e.r = (c != 0) ? 8'(lvl) : 8'd0;
                e.g = e.r; e.b = e.r;
            end
            4: begin
                e.r = sol[23:16]; e.g = sol[15:8]; e.b = sol[7:0];
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [2:0] rm();
        return 3'($urandom_range(7));
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(1));
    endfunction

    function automatic logic [23:0] sol(bit fix);
        return fix ? 24'h0a141e : 24'($urandom);
    endfunction

    // One clock of stimulus: drive, predict the output two cycles out, advance the model
    task automatic drive(input bit rst, input bit nf, input bit nl, input bit np, input bit vis,
                         input logic [2:0] md, input bit l100, input bit rv, input logic [23:0] s);
        exp_t e;
        int   nsc;
        @(posedge clk); #1;
        reset = rst; newframe = nf; newline = nl; newpixel = np; visible_window = vis;
        mode = md; level_100 = l100; reverse = rv; solid_rgb = s;
        if (rst) begin
            // the pipeline is cleared, so the output of the previous cycle is lost too
            for (int i = 0; i < sbq.size(); i++) begin
                if (sbq[i].cyc >= cyc - 1) begin
                    e = sbq[i];
                    e.vld = 1'b0; e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
                    sbq[i] = e;
                end
            end
            e.vld = 1'b0; e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
            m_px = 0; m_ly = 0; m_sc = 0; m_mode = 0; m_l100 = 1'b1; m_rev = 1'b0;
        end else begin
            e = model_out(m_px, m_ly, m_sc, m_mode, m_l100, m_rev, vis, s);
            nsc = (nf && m_mode == 3) ? (m_sc + STEP) % H : m_sc;
            if (nl) m_px = 0;
            else if (vis && np && m_px < H) m_px = m_px + 1;
            if (nf) m_ly = 0;
            else if (nl) m_ly = (m_ly + 1) % (1 << LW);
            if (nl) begin
                m_mode = int'(md); m_l100 = l100; m_rev = rv;
            end
            m_sc = nsc;
        end
        e.cyc = cyc;
        sbq.push_back(e);
    endtask

    // One line: newline (with coincident newpixel) carrying the config, then garbage config mid-line
    task automatic line(input bit nf, input logic [2:0] md, input bit l100, input bit rv,
                        input int nvis, input int pnp, input int rst_at, input bit fix);
        drive(1'b0, nf, 1'b1, 1'b1, rb(), md, l100, rv, sol(fix));
        repeat (2) drive(1'b0, 1'b0, 1'b0, rb(), 1'b0, rm(), rb(), rb(), sol(fix));
        for (int i = 0; i < nvis; i++)
            drive(bit'(i == rst_at), 1'b0, 1'b0, bit'($urandom_range(99) < pnp), 1'b1,
                  rm(), rb(), rb(), sol(fix));
        repeat (2) drive(1'b0, 1'b0, 1'b0, rb(), 1'b0, rm(), rb(), rb(), sol(fix));
    endtask

    // Monitor: every cycle the DUT presents a pixel; compare against the entry from two cycles back
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0 && sbq[0].cyc == cyc - 2) begin
            e = sbq.pop_front();
            total++;
            if ({out_valid, out_r, out_g, out_b} !== {e.vld, e.r, e.g, e.b}) begin
                bad++;
                $display("FAIL pixel cyc=%0d got vld=%0b rgb=(%0d,%0d,%0d) want vld=%0b rgb=(%0d,%0d,%0d)",
                         cyc, out_valid, out_r, out_g, out_b, e.vld, e.r, e.g, e.b);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 24'd0);
        // bars at 100%, then 75% reversed
        line(1'b1, 3'd0, 1'b1, 1'b0, 264, 100, -1, 1'b0);
        line(1'b0, 3'd0, 1'b0, 1'b1, 264, 100, -1, 1'b0);
        // ramp, normal and reversed, running past the end of the line
        line(1'b0, 3'd1, 1'b1, 1'b0, 270, 100, -1, 1'b0);
        line(1'b0, 3'd1, 1'b0, 1'b1, 270, 100, -1, 1'b0);
        // checker across 21 lines of a new frame
        line(1'b1, 3'd2, 1'b1, 1'b0, 48, 100, -1, 1'b0);
        for (int l = 0; l < 20; l++) line(1'b0, 3'd2, rb(), rb(), 48, 100, -1, 1'b0);
        // scrolling bars over enough frames to wrap the offset
        for (int f = 0; f < 260; f++)
            line(1'b1, 3'd3, rb(), rb(), int'($urandom_range(8, 40)), 100, -1, 1'b0);
        line(1'b0, 3'd3, 1'b1, 1'b0, 264, 100, -1, 1'b0);
        // solid, and the black modes
        line(1'b0, 3'd4, 1'b1, 1'b0, 40, 100, -1, 1'b1);
        line(1'b0, 3'd6, 1'b1, 1'b0, 40, 100, -1, 1'b0);
        line(1'b0, 3'd5, 1'b0, 1'b1, 40, 100, -1, 1'b0);
        line(1'b0, 3'd7, 1'b1, 1'b1, 40, 100, -1, 1'b0);
        // reset in the middle of a reversed bar line
        line(1'b0, 3'd0, 1'b1, 1'b1, 100, 100, 40, 1'b0);
        // random mix with sparse newpixel and occasional resets
        repeat (30)
            line(rb(), rm(), rb(), rb(), int'($urandom_range(0, 300)), int'($urandom_range(30, 100)),
                 ($urandom_range(9) == 0) ? int'($urandom_range(0, 50)) : -1, rb());
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 24'd0);
        @(negedge clk); #1;
        total++;
        if (sbq.size() > 2) begin
            bad++;
            $display("FAIL drain left=%0d want<=2", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
